led_pwm_multi: RTL and testbench

Multi-channel LED PWM driver, generalised from the single-channel pushbutton-dimmed LED. It has one shared period counter with a prescaler and per-channel duty registers. Duty adjustment saturates instead of wrapping. Each channel has a mode: off, static, breathe (triangle ramp) or blink. It sits between debounced board pushbuttons/switches and the LED pins.

---
 rtl/led_pwm_multi_if.sv | 21 ++
 rtl/led_pwm_multi.sv | 143 ++++++++++++++
 tb/tb_led_pwm_multi.sv | 254 +++++++++++++++++++++++++
 3 files changed

// File: rtl/led_pwm_multi_if.sv
// rtl/led_pwm_multi_if.sv - control bus for the multi-channel LED PWM driver
interface led_pwm_multi_if #(
    parameter int channels_p = 4
);
    localparam int sel_w = (channels_p > 1) ? $clog2(channels_p) : 1;

    logic             en_i;
    logic [sel_w-1:0] sel_i;
    logic             incr_i;
    logic             decr_i;
    logic [1:0]       mode_i;
    logic             mode_we_i;

    modport master (
        output en_i, sel_i, incr_i, decr_i, mode_i, mode_we_i
    );

    modport slave (
        input en_i, sel_i, incr_i, decr_i, mode_i, mode_we_i
    );
endinterface

// File: rtl/led_pwm_multi.sv
// rtl/led_pwm_multi.sv - multi-channel LED PWM with shared prescaled period counter
module led_pwm_multi #(
    parameter int channels_p = 4,
    parameter int bits_p     = 8,
    parameter int prescale_p = 1
) (
    input  logic                  clk_i,
    input  logic                  reset_i,
    led_pwm_multi_if.slave        ctl,
    output logic [channels_p-1:0] led_o,
    output logic                  period_o
);
    typedef enum logic [1:0] {
        MODE_OFF     = 2'd0,
        MODE_STATIC  = 2'd1,
        MODE_BREATHE = 2'd2,
        MODE_BLINK   = 2'd3
    } mode_e;

    localparam int pw = (prescale_p > 1) ? $clog2(prescale_p) : 1;
    localparam logic [pw-1:0] presc_max = pw'(prescale_p - 1);

    logic [pw-1:0]           presc_q, presc_d;
    logic [bits_p-1:0]       count_q, count_d;
    logic                    period_q, period_d;
    logic [channels_p-1:0]   led_q, led_d;
    logic [bits_p-1:0]       duty_q  [channels_p];
    logic [bits_p-1:0]       duty_d  [channels_p];
    logic [bits_p-1:0]       level_q [channels_p];
    logic [bits_p-1:0]       level_d [channels_p];
    mode_e                   mode_q  [channels_p];
    mode_e                   mode_d  [channels_p];
    logic [channels_p-1:0]   dir_q, dir_d;       // 1 = ramping down
    logic [channels_p-1:0]   phase_q, phase_d;   // 1 = blink off half
    logic [bits_p-1:0]       eff     [channels_p];
    logic                    tick;
    logic                    wrap;
    logic                    sel_hit;

    always_comb begin
        presc_d  = presc_q;
        count_d  = count_q;
        tick     = ctl.en_i && (presc_q == presc_max);
        wrap     = tick && (count_q == '1);
        period_d = wrap;
        led_d    = '0;
        dir_d    = dir_q;
        phase_d  = phase_q;
        sel_hit  = 1'b0;

        if (ctl.en_i) begin
            presc_d = tick ? '0 : presc_q + 1'b1;
            if (tick) begin
                count_d = count_q + 1'b1;
            end
        end

        for (int c = 0; c < channels_p; c++) begin
            duty_d[c]  = duty_q[c];
            level_d[c] = level_q[c];
            mode_d[c]  = mode_q[c];
            eff[c]     = '0;
            sel_hit    = (int'(ctl.sel_i) == c);

            if (ctl.en_i && sel_hit && ctl.incr_i && !ctl.decr_i && duty_q[c] != '1) begin
                duty_d[c] = duty_q[c] + 1'b1;
            end else if (ctl.en_i && sel_hit && ctl.decr_i && !ctl.incr_i && duty_q[c] != '0) begin
                duty_d[c] = duty_q[c] - 1'b1;
            end

            if (wrap) begin
                case (mode_q[c])
                    MODE_BLINK: phase_d[c] = ~phase_q[c];
                    MODE_BREATHE: begin
                        if (!dir_q[c]) begin
                            if (level_q[c] >= duty_q[c]) begin
                                level_d[c] = duty_q[c];
                                dir_d[c]   = 1'b1;
                            end else begin
                                level_d[c] = level_q[c] + 1'b1;
                            end
                        end else if (level_q[c] > duty_q[c]) begin
                            level_d[c] = duty_q[c];
                        end else if (level_q[c] == '0) begin
                            dir_d[c] = 1'b0;
                        end else begin
                            level_d[c] = level_q[c] - 1'b1;
                        end
                    end
                    default: ;
                endcase
            end

            // A mode write restarts the ramp/blink even if a wrap lands in the same cycle.
            if (ctl.mode_we_i && sel_hit) begin
                mode_d[c]  = mode_e'(ctl.mode_i);
                level_d[c] = '0;
                dir_d[c]   = 1'b0;
                phase_d[c] = 1'b0;
            end

            case (mode_q[c])
                MODE_STATIC:  eff[c] = duty_q[c];
                MODE_BREATHE: eff[c] = level_q[c];
                MODE_BLINK:   eff[c] = phase_q[c] ? '0 : duty_q[c];
                default:      eff[c] = '0;
            endcase

            led_d[c] = ctl.en_i && (count_q < eff[c]);
        end
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            presc_q  <= '0;
            count_q  <= '0;
            period_q <= 1'b0;
            led_q    <= '0;
            dir_q    <= '0;
            phase_q  <= '0;
            for (int c = 0; c < channels_p; c++) begin
                duty_q[c]  <= '0;
                level_q[c] <= '0;
                mode_q[c]  <= MODE_OFF;
            end
        end else begin
            presc_q  <= presc_d;
            count_q  <= count_d;
            period_q <= period_d;
            led_q    <= led_d;
            dir_q    <= dir_d;
            phase_q  <= phase_d;
            for (int c = 0; c < channels_p; c++) begin
                duty_q[c]  <= duty_d[c];
                level_q[c] <= level_d[c];
                mode_q[c]  <= mode_d[c];
            end
        end
    end

    assign led_o    = led_q;
    assign period_o = period_q;
endmodule

// File: tb/tb_led_pwm_multi.sv
// tb/tb_led_pwm_multi.sv - directed self-checking bench for led_pwm_multi
module tb_led_pwm_multi;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [1:0] led_a;
    logic       per_a;
    logic [2:0] led_b;
    logic       per_b;
    int         checks = 0;
    int         passes = 0;

    always #5 clk = ~clk;

    led_pwm_multi_if #(.channels_p(2)) bus_a ();
    led_pwm_multi_if #(.channels_p(3)) bus_b ();

    led_pwm_multi #(.channels_p(2), .bits_p(4), .prescale_p(1)) u_a (
        .clk_i(clk), .reset_i(rst), .ctl(bus_a), .led_o(led_a), .period_o(per_a));
    led_pwm_multi #(.channels_p(3), .bits_p(4), .prescale_p(3)) u_b (
        .clk_i(clk), .reset_i(rst), .ctl(bus_b), .led_o(led_b), .period_o(per_b));

    task automatic step;
        @(negedge clk);
    endtask

    task automatic drive_a(input int sel, input bit inc, input bit dec, input int n);
        bus_a.sel_i = 1'(sel); bus_a.incr_i = inc; bus_a.decr_i = dec;
        repeat (n) step();
        bus_a.incr_i = 1'b0; bus_a.decr_i = 1'b0;
    endtask

    task automatic drive_b(input int sel, input bit inc, input bit dec, input int n);
        bus_b.sel_i = 2'(sel); bus_b.incr_i = inc; bus_b.decr_i = dec;
        repeat (n) step();
        bus_b.incr_i = 1'b0; bus_b.decr_i = 1'b0;
    endtask

    task automatic mode_a(input int sel, input logic [1:0] m);
        bus_a.sel_i = 1'(sel); bus_a.mode_i = m; bus_a.mode_we_i = 1'b1;
        step();
        bus_a.mode_we_i = 1'b0;
    endtask

    task automatic mode_b(input int sel, input logic [1:0] m);
        bus_b.sel_i = 2'(sel); bus_b.mode_i = m; bus_b.mode_we_i = 1'b1;
        step();
        bus_b.mode_we_i = 1'b0;
    endtask

    task automatic sync_a;
        int n = 0;
        step();
        while (!per_a && n < 100) begin step(); n++; end
        checks++;
        if (per_a !== 1'b1) $display("FAIL sync_a: period_o=%0b expected 1 within 100 cycles", per_a);
        else passes++;
    endtask

    task automatic sync_b;
        int n = 0;
        step();
        while (!per_b && n < 200) begin step(); n++; end
        checks++;
        if (per_b !== 1'b1) $display("FAIL sync_b: period_o=%0b expected 1 within 200 cycles", per_b);
        else passes++;
    endtask

    task automatic measure_a(input int ch, output int on, output int len);
        on = 0; len = 0;
        do begin step(); len++; if (led_a[ch]) on++; end while (!per_a && len < 200);
    endtask

    task automatic measure_b(input int ch, output int on, output int len);
        on = 0; len = 0;
        do begin step(); len++; if (led_b[ch]) on++; end while (!per_b && len < 200);
    endtask

    task automatic test_reset;
        checks++;
        if ({led_a, per_a, led_b, per_b} !== 7'b0)
            $display("FAIL reset_hold: outputs=%b expected 0", {led_a, per_a, led_b, per_b});
        else passes++;
        rst = 1'b0;
        bus_a.en_i = 1'b1; bus_b.en_i = 1'b1;
        step();
        checks++;
        if ({led_a, per_a, led_b, per_b} !== 7'b0)
            $display("FAIL reset_release: outputs=%b expected 0", {led_a, per_a, led_b, per_b});
        else passes++;
    endtask

    task automatic test_static;
        int on, len;
        mode_a(0, 2'd1);
        drive_a(0, 1, 0, 3);
        sync_a();
        for (int k = 1; k <= 16; k++) begin
            step();
            checks++;
            if (led_a[0] !== ((k - 1) < 3) || per_a !== (k == 16))
                $display("FAIL static_k%0d: led=%0b period=%0b expected led=%0b period=%0b",
                         k, led_a[0], per_a, ((k - 1) < 3), (k == 16));
            else passes++;
        end
        measure_a(0, on, len);
        checks++;
        if (on !== 3 || len !== 16) $display("FAIL static_period: on=%0d len=%0d expected on=3 len=16", on, len);
        else passes++;
    endtask

    task automatic test_saturation;
        int on, len;
        drive_a(0, 1, 0, 20);
        sync_a(); measure_a(0, on, len);
        checks++;
        if (on !== 15) $display("FAIL sat_high: on=%0d expected 15", on);
        else passes++;
        drive_a(0, 0, 1, 20);
        sync_a(); measure_a(0, on, len);
        checks++;
        if (on !== 0) $display("FAIL sat_low: on=%0d expected 0", on);
        else passes++;
        drive_a(0, 1, 0, 4);
        drive_a(0, 1, 1, 5);
        sync_a(); measure_a(0, on, len);
        checks++;
        if (on !== 4) $display("FAIL incr_decr_both: on=%0d expected 4", on);
        else passes++;
    endtask

    task automatic test_breathe;
        int on, len;
        int exp_on [8] = '{1, 2, 2, 1, 0, 0, 1, 2};
        drive_a(1, 1, 0, 2);
        mode_a(1, 2'd2);
        sync_a();
        for (int i = 0; i < 8; i++) begin
            measure_a(1, on, len);
            checks++;
            if (on !== exp_on[i] || len !== 16)
                $display("FAIL breathe_p%0d: on=%0d len=%0d expected on=%0d len=16", i, on, len, exp_on[i]);
            else passes++;
        end
    endtask

    task automatic test_gating;
        int on, len, n;
        bit bad = 1'b0;
        sync_a(); step(); step();
        bus_a.en_i = 1'b0; bus_a.sel_i = 1'b0; bus_a.incr_i = 1'b1;
        for (int i = 0; i < 10; i++) begin
            step();
            if ({led_a, per_a} !== 3'b0) bad = 1'b1;
        end
        checks++;
        if (bad) $display("FAIL gate_outputs: led/period active while disabled, expected 0");
        else passes++;
        bus_a.en_i = 1'b1; bus_a.incr_i = 1'b0;
        n = 0;
        do begin step(); n++; end while (!per_a && n < 100);
        checks++;
        if (n !== 14) $display("FAIL gate_count_frozen: wrap after %0d cycles expected 14", n);
        else passes++;
        measure_a(0, on, len);
        checks++;
        if (on !== 4) $display("FAIL gate_incr_ignored: on=%0d expected 4", on);
        else passes++;
    endtask

    task automatic test_blink;
        int on, len;
        int exp_on [4] = '{0, 15, 0, 15};
        drive_b(0, 1, 0, 5);
        mode_b(0, 2'd3);
        sync_b();
        for (int i = 0; i < 4; i++) begin
            measure_b(0, on, len);
            checks++;
            if (on !== exp_on[i] || len !== 48)
                $display("FAIL blink_p%0d: on=%0d len=%0d expected on=%0d len=48", i, on, len, exp_on[i]);
            else passes++;
        end
    endtask

    task automatic test_out_of_range;
        int on1, on2, len;
        bit bad = 1'b0;
        mode_b(1, 2'd1);
        mode_b(2, 2'd1);
        drive_b(3, 1, 0, 4);
        mode_b(3, 2'd0);
        sync_b();
        measure_b(0, on1, len);
        measure_b(0, on2, len);
        checks++;
        if (on1 + on2 !== 15 || (on1 !== 0 && on2 !== 0))
            $display("FAIL oor_ch0_blink: on=%0d,%0d expected one period 15 and one 0", on1, on2);
        else passes++;
        for (int i = 0; i < 48; i++) begin
            step();
            if (led_b[2:1] !== 2'b0) bad = 1'b1;
        end
        checks++;
        if (bad) $display("FAIL oor_ch12: led[2:1] went high expected 0");
        else passes++;
    endtask

    task automatic test_async_reset;
        int n = 0;
        bit bad = 1'b0;
        while (!led_a[0] && n < 100) begin step(); n++; end
        checks++;
        if (led_a[0] !== 1'b1) $display("FAIL pre_reset_led: led=%0b expected 1", led_a[0]);
        else passes++;
        #2 rst = 1'b1;
        #1;
        checks++;
        if ({led_a, per_a, led_b, per_b} !== 7'b0)
            $display("FAIL async_reset_led: outputs=%b expected 0", {led_a, per_a, led_b, per_b});
        else passes++;
        step();
        rst = 1'b0;
        n = 0;
        do begin step(); n++; if (led_a !== 2'b0) bad = 1'b1; end while (!per_a && n < 100);
        checks++;
        if (n !== 16 || bad) $display("FAIL post_reset: wrap after %0d cycles led_seen=%0b expected 16 and 0", n, bad);
        else passes++;
        #2 rst = 1'b1;
        #1;
        checks++;
        if (per_a !== 1'b0) $display("FAIL async_reset_period: period_o=%0b expected 0", per_a);
        else passes++;
        step();
        rst = 1'b0;
    endtask

    initial begin
        bus_a.en_i = 1'b0; bus_a.sel_i = '0; bus_a.incr_i = 1'b0; bus_a.decr_i = 1'b0;
        bus_a.mode_i = '0; bus_a.mode_we_i = 1'b0;
        bus_b.en_i = 1'b0; bus_b.sel_i = '0; bus_b.incr_i = 1'b0; bus_b.decr_i = 1'b0;
        bus_b.mode_i = '0; bus_b.mode_we_i = 1'b0;
        repeat (2) step();
        test_reset();
        test_static();
        test_saturation();
        test_breathe();
        test_gating();
        test_blink();
        test_out_of_range();
        test_async_reset();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule
